// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared constants and types for the sram_arbiter slice
// Owner encoding, FSM state encoding and fixed bus widths.
package sram_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side request/response bus of sram_arbiter
// Ports (all signals, grouped by requester):
//   i_req_valid/ready/addr, i_rsp_valid/ready/data       instruction fetch
//   d_req_valid/ready/write/addr/wdata/wmask,
//   d_rsp_valid/ready/data                                data load/store
// Modports: master = requester side, slave = arbiter side.
interface sram_arbiter_if #(
    parameter int addr_width = 8
);
    import sram_arbiter_pkg::*;

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [addr_width-1:0] i_req_addr;
    logic                  i_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] i_rsp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_write;
    logic [addr_width-1:0] d_req_addr;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic [MASK_WIDTH-1:0] d_req_wmask;
    logic                  d_rsp_valid;
    logic                  d_rsp_ready;
    logic [DATA_WIDTH-1:0] d_rsp_data;

    modport master (
        output i_req_valid, i_req_addr, i_rsp_ready,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_wmask, d_rsp_ready,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_rsp_ready,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_wmask, d_rsp_ready,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data
    );

endinterface

// File: rtl/sram_1r1w.sv
// rtl/sram_1r1w.sv - single-port word memory with byte-masked write and registered read
// Ports: clock; en (access), wen (1 = write), addr, din, wmask (byte enables);
//        dout (read data, updated only by a read access, otherwise held).
module sram_1r1w
    import sram_arbiter_pkg::*;
#(
    parameter int addr_width = 8
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  wen,
    input  logic [addr_width-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [MASK_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << addr_width)-1];

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (wen) begin
                for (int b = 0; b < MASK_WIDTH; b++) begin
                    if (wmask[b]) begin
                        mem[addr][8*b +: 8] <= din[8*b +: 8];
                    end
                end
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_arbiter_rr_arb2.sv
// rtl/sram_arbiter_rr_arb2.sv - two-requester round-robin grant with last-owner register
// Ports: clock, reset (sync, active-high); grant_enable; req_i, req_d;
//        gnt_i, gnt_d (combinational, at most one high).
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic grant_enable,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    logic last;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (grant_enable) begin
            if (req_i && req_d) begin
                // Tie: favour whichever port was not served last.
                gnt_i = (last == PORT_D);
                gnt_d = (last == PORT_I);
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    // Resetting to D makes I win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= PORT_D;
        end else if (gnt_i) begin
            last <= PORT_I;
        end else if (gnt_d) begin
            last <= PORT_D;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin sharing of one sram_1r1w between I-fetch and D load/store
// Ports: clock; reset (sync, active-high); bus (sram_arbiter_if.slave) carrying the
//        I request/response and D request/response valid/ready channels.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int addr_width = 8
) (
    input  logic         clock,
    input  logic         reset,
    sram_arbiter_if.slave bus
);

    state_t state;
    logic   owner;
    logic   is_write;
    logic   armed;      // low in the first cycle after reset to keep all outputs quiet

    logic gnt_i;
    logic gnt_d;
    logic rsp_hs;
    logic grant_enable;

    logic                  sram_en;
    logic                  sram_wen;
    logic [addr_width-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [MASK_WIDTH-1:0] sram_wmask;
    logic [DATA_WIDTH-1:0] sram_dout;

    logic i_rsp_valid;
    logic d_rsp_valid;

    assign i_rsp_valid = (state == ST_RESP) && (owner == PORT_I);
    assign d_rsp_valid = (state == ST_RESP) && (owner == PORT_D);

    // A new grant may overlap the cycle in which the pending response is taken,
    // giving one access per cycle when both sides keep up.
    assign rsp_hs       = (i_rsp_valid && bus.i_rsp_ready) || (d_rsp_valid && bus.d_rsp_ready);
    assign grant_enable = armed && ((state == ST_IDLE) || rsp_hs);

    rr_arb2 u_arb (
        .clock        (clock),
        .reset        (reset),
        .grant_enable (grant_enable),
        .req_i        (bus.i_req_valid),
        .req_d        (bus.d_req_valid),
        .gnt_i        (gnt_i),
        .gnt_d        (gnt_d)
    );

    assign sram_en    = gnt_i || gnt_d;
    assign sram_wen   = gnt_d && bus.d_req_write;
    assign sram_addr  = gnt_d ? bus.d_req_addr : bus.i_req_addr;
    assign sram_din   = gnt_d ? bus.d_req_wdata : '0;
    assign sram_wmask = sram_wen ? bus.d_req_wmask : '0;

    sram_1r1w #(
        .addr_width (addr_width)
    ) u_sram (
        .clock (clock),
        .en    (sram_en),
        .wen   (sram_wen),
        .addr  (sram_addr),
        .din   (sram_din),
        .wmask (sram_wmask),
        .dout  (sram_dout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= PORT_I;
            is_write <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (gnt_i || gnt_d) begin
                state    <= ST_RESP;
                owner    <= gnt_d ? PORT_D : PORT_I;
                is_write <= gnt_d && bus.d_req_write;
            end else if (rsp_hs) begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.i_req_ready = gnt_i;
    assign bus.d_req_ready = gnt_d;
    assign bus.i_rsp_valid = i_rsp_valid;
    assign bus.d_rsp_valid = d_rsp_valid;
    // dout is only meaningful while a read response is owned; otherwise drive 0.
    assign bus.i_rsp_data  = i_rsp_valid ? sram_dout : '0;
    assign bus.d_rsp_data  = (d_rsp_valid && !is_write) ? sram_dout : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    sram_arbiter_if #(.addr_width(8)) bus ();

    sram_arbiter #(.addr_width(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts from an idle arbiter at posedge+1; leaves it idle at posedge+1.
    task automatic d_write(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] m);
        bus.d_req_valid = 1'b1;
        bus.d_req_write = 1'b1;
        bus.d_req_addr  = a;
        bus.d_req_wdata = wd;
        bus.d_req_wmask = m;
        #1;
        check("dw_req_ready", {31'd0, bus.d_req_ready}, 32'd1);
        tick();
        bus.d_req_valid = 1'b0;
        bus.d_req_write = 1'b0;
        #1;
        check("dw_rsp_valid", {31'd0, bus.d_rsp_valid}, 32'd1);
        check("dw_rsp_data", bus.d_rsp_data, 32'd0);
        tick();
    endtask

    task automatic d_read(input logic [7:0] a, input logic [31:0] exp);
        bus.d_req_valid = 1'b1;
        bus.d_req_write = 1'b0;
        bus.d_req_addr  = a;
        #1;
        check("dr_req_ready", {31'd0, bus.d_req_ready}, 32'd1);
        tick();
        bus.d_req_valid = 1'b0;
        #1;
        check("dr_rsp_valid", {31'd0, bus.d_rsp_valid}, 32'd1);
        check("dr_rsp_data", bus.d_rsp_data, exp);
        tick();
    endtask

    task automatic i_read(input logic [7:0] a, input logic [31:0] exp);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = a;
        #1;
        check("ir_req_ready", {31'd0, bus.i_req_ready}, 32'd1);
        tick();
        bus.i_req_valid = 1'b0;
        #1;
        check("ir_rsp_valid", {31'd0, bus.i_rsp_valid}, 32'd1);
        check("ir_rsp_data", bus.i_rsp_data, exp);
        tick();
    endtask

    initial begin
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 8'd0;
        bus.i_rsp_ready = 1'b1;
        bus.d_req_valid = 1'b1;
        bus.d_req_write = 1'b0;
        bus.d_req_addr  = 8'd0;
        bus.d_req_wdata = 32'd0;
        bus.d_req_wmask = 4'd0;
        bus.d_rsp_ready = 1'b1;

        // Reset held 3 cycles with both requests pending: everything quiet.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_outputs", {26'd0, bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid,
                                  bus.d_rsp_valid, |bus.i_rsp_data, |bus.d_rsp_data}, 32'd0);
        end
        reset = 1'b0;
        #1;
        check("post_rst_quiet", {26'd0, bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid,
                                 bus.d_rsp_valid, |bus.i_rsp_data, |bus.d_rsp_data}, 32'd0);
        tick();
        check("first_tie_i", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'b10);
        tick();
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        #1;
        check("first_rsp_owner", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'b10);
        tick();
        check("idle_again", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'b00);

        // Byte-masked write then readback.
        d_write(8'd5, 32'hAABBCCDD, 4'hF);
        d_write(8'd5, 32'h11223344, 4'h5);
        d_read(8'd5, 32'hAA22CC44);

        // Zero mask: slot taken, acknowledged, memory unchanged.
        d_write(8'd5, 32'hDEADBEEF, 4'h0);
        d_read(8'd5, 32'hAA22CC44);

        // Back-to-back read-after-write to the same address.
        bus.d_req_valid = 1'b1;
        bus.d_req_write = 1'b1;
        bus.d_req_addr  = 8'd10;
        bus.d_req_wdata = 32'h0BADCAFE;
        bus.d_req_wmask = 4'hF;
        tick();
        bus.d_req_write = 1'b0;
        #1;
        check("raw_wr_ack", {30'd0, bus.d_rsp_valid, bus.d_req_ready}, 32'b11);
        check("raw_wr_data", bus.d_rsp_data, 32'd0);
        tick();
        bus.d_req_valid = 1'b0;
        #1;
        check("raw_rd_data", bus.d_rsp_data, 32'h0BADCAFE);
        tick();

        // Contention: last = D, so I, D, I, D ... one grant per cycle.
        d_write(8'd7, 32'h77777777, 4'hF);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 8'd5;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 8'd7;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("cont_grant", {30'd0, bus.i_req_ready, bus.d_req_ready},
                  (k % 2 == 0) ? 32'b10 : 32'b01);
            if (k > 0) begin
                check("cont_rsp_owner", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid},
                      (k % 2 == 1) ? 32'b10 : 32'b01);
                check("cont_rsp_data", (k % 2 == 1) ? bus.i_rsp_data : bus.d_rsp_data,
                      (k % 2 == 1) ? 32'hAA22CC44 : 32'h77777777);
            end
            tick();
        end
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        #1;
        check("cont_last_rsp", bus.d_rsp_data, 32'h77777777);
        tick();

        // Response stall on I while D waits.
        d_write(8'd3, 32'h12345678, 4'hF);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 8'd3;
        bus.i_rsp_ready = 1'b0;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 8'd5;
        #1;
        check("stall_grant_i", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'b10);
        tick();
        bus.i_req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_i_data", bus.i_rsp_data, 32'h12345678);
            check("stall_d_blocked", {30'd0, bus.i_rsp_valid, bus.d_req_ready}, 32'b10);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        #1;
        check("stall_release_d", {31'd0, bus.d_req_ready}, 32'd1);
        tick();
        bus.d_req_valid = 1'b0;
        #1;
        check("stall_d_rsp", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'b01);
        check("stall_d_data", bus.d_rsp_data, 32'hAA22CC44);
        tick();

        // Reset while a D response is pending.
        d_write(8'd9, 32'hCAFEF00D, 4'hF);
        bus.d_rsp_ready = 1'b0;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 8'd9;
        tick();
        bus.d_req_valid = 1'b0;
        #1;
        check("mid_rsp_pending", {31'd0, bus.d_rsp_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_drop", {31'd0, bus.d_rsp_valid}, 32'd0);
        reset = 1'b0;
        bus.d_rsp_ready = 1'b1;
        #1;
        check("mid_post_rst", {30'd0, bus.d_rsp_valid, bus.d_req_ready}, 32'd0);
        tick();
        check("mid_no_rsp", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'd0);
        d_read(8'd9, 32'hCAFEF00D);

        // Top and bottom addresses hold distinct data.
        d_write(8'd255, 32'hFFFF0000, 4'hF);
        d_write(8'd0, 32'h0000BEEF, 4'hF);
        d_read(8'd255, 32'hFFFF0000);
        d_read(8'd0, 32'h0000BEEF);
        i_read(8'd255, 32'hFFFF0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one `sram_1r1w` macro (single address port, byte-masked write, registered read) between the core's instruction-fetch port and its data load/store port. Arbitration is round-robin, with one outstanding access at a time. A valid/ready response channel per requester holds read data until the requester accepts it. Sits between the copperv core bus interface and on-chip memory.

## Interface
- `addr_width`, 8, word address width; memory depth is 2^addr_width words
- `data_width`, 32, fixed
- `mask_width`, 4, fixed (`data_width/8`)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_req_valid`  in  1  instruction read request
- `i_req_ready`  out  1  request accepted this cycle
- `i_req_addr`  in  addr_width  word address
- `i_rsp_valid`  out  1  read data available
- `i_rsp_ready`  in  1  requester takes data
- `i_rsp_data`  out  32  read data
- `d_req_valid`  in  1  data request
- `d_req_ready`  out  1  accepted
- `d_req_write`  in  1  1 = write, 0 = read
- `d_req_addr`  in  addr_width  word address
- `d_req_wdata`  in  32  write data
- `d_req_wmask`  in  4  byte enables; bit n covers bits 8n+7:8n
- `d_rsp_valid`  out  1  read data or write acknowledge
- `d_rsp_ready`  in  1  accepted
- `d_rsp_data`  out  32  read data; 0 for write acknowledges

## Operation
- FSM, two states:
  - IDLE: no access outstanding.
  - RESP: one access completed; its response is presented to its owner.
- Grant is allowed when the state is IDLE, or when the state is RESP and the current response handshakes this cycle (`*_rsp_valid && *_rsp_ready`). This gives back-to-back throughput of 1 access/cycle.
- Arbitration when grant is allowed:
  - Only one valid request: grant it.
  - Both valid: grant the port not granted last. `last` resets to D, so I wins the first tie.
- `*_req_ready` is combinational and equals the grant. SRAM `en` equals (any grant). `wen` equals the D grant && `d_req_write`. `addr`, `din` and `wmask` are muxed from the granted port. `wmask` is 0 for reads.
- On grant:
  - The state goes to RESP.
  - The owner (I/D) and an is-write flag are registered.
  - `last` is set to the owner.
- In RESP:
  - Only the owner's `rsp_valid` is high.
  - `rsp_data` is the SRAM `dout`. `dout` holds because no new read occurs until the handshake.
  - For writes, `d_rsp_data` is 0.
- Handshake with no grant allowed: the state returns to IDLE.
- A write with `wmask`=0 still takes a slot and returns an acknowledge, but memory is unchanged.
- Reset mid-operation drops the pending response. Memory contents are not cleared.

## Timing
- While `reset` is high, and in the first cycle after it, all outputs are 0: `*_req_ready`, `*_rsp_valid`, `*_rsp_data`. State = IDLE, `last` = D.
- Latency: a request granted at edge T has its response valid in the cycle after T, i.e. 1 cycle from acceptance.
- A response stays valid, with stable data, until ready. No new grant is made to either port while it is stalled.
- `*_req_ready` may depend combinationally on `*_req_valid` and `*_rsp_ready`. No output depends combinationally on `*_req_addr` or `*_req_wdata`.
- Read-after-write to the same address, back-to-back: the read is granted the cycle after the write and returns the new data.
- Requesters must hold valid and payload stable until ready.

## Structure
- A shared package holds:
  - owner encoding constants (`PORT_I`=0, `PORT_D`=1)
  - FSM state encoding (`ST_IDLE`, `ST_RESP`)
- Instantiates `sram_1r1w` with `addr_width` passed through.
- One sub-module: `rr_arb2`. It contains the two-request round-robin grant logic with the `last` register, and takes a `grant_enable` input.
- Size estimate: ~200 lines total.

## Test plan
- **Reset values:** hold reset 3 cycles with both req_valid high. Required: all readies and rsp_valids stay 0 until the first cycle after reset; the first grant goes to I.
- **Byte-masked write then readback:** D writes 0xAABBCCDD to address 5 with mask 0xF, then writes 0x11223344 with mask 0x5, then reads address 5. Required: read returns 0xAA22CC44 exactly 1 cycle after acceptance; both write acks have `d_rsp_data`=0.
- **Contention:** I and D request continuously with rsp_ready tied high. Required: grants alternate I, D, I, D, one per cycle, and each response returns to the correct owner.
- **Response stall:** I reads address 3 (holding 0x12345678) and holds `i_rsp_ready` low for 4 cycles while D requests. Required: `i_rsp_data` is stable at 0x12345678 and `d_req_ready` stays 0; D is granted in the cycle `i_rsp_ready` rises.
- **Reset mid-response:** assert reset while `d_rsp_valid` is pending. Required: rsp_valid drops and no response appears after reset; memory written before the reset still reads back.
- **Address wrap:** with `addr_width`=8, write address 255 and read address 0. Required: the data at each address is distinct (no aliasing).
